// File: rtl/acc_shift_scheduler_if.sv
// Job command, shifter control, SRAM port and completion signals of acc_shift_scheduler.
// The master side is the surrounding system; the scheduler connects to the slave side.
interface acc_shift_scheduler_if #(
  parameter int ADDR_W = 10,
  parameter int CH     = 32,
  parameter int TAG_W  = 4
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [ADDR_W-1:0]      cmd_base;
  logic [ADDR_W-1:0]      cmd_size;
  logic [CH-1:0]          cmd_ctrl;
  logic [TAG_W-1:0]       cmd_tag;
  logic                   shift_start;
  logic                   shift_idle;
  logic [CH-1:0]          shift_ctrl;
  logic [ADDR_W*CH-1:0]   start_addr;
  logic [ADDR_W-1:0]      img_size;
  logic                   shf_sram_en;
  logic [ADDR_W-1:0]      shf_sram_addr;
  logic                   host_we;
  logic [ADDR_W-1:0]      host_addr;
  logic [CH-1:0]          host_wdata;
  logic                   host_ready;
  logic                   sram_en;
  logic                   sram_we;
  logic [ADDR_W-1:0]      sram_addr;
  logic [CH-1:0]          sram_wdata;
  logic                   done_valid;
  logic [TAG_W-1:0]       done_tag;
  logic                   done_err;
  logic                   busy;

  modport master (
    output cmd_valid, cmd_base, cmd_size, cmd_ctrl, cmd_tag, shift_idle,
           shf_sram_en, shf_sram_addr, host_we, host_addr, host_wdata,
    input  cmd_ready, shift_start, shift_ctrl, start_addr, img_size, host_ready,
           sram_en, sram_we, sram_addr, sram_wdata, done_valid, done_tag, done_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_base, cmd_size, cmd_ctrl, cmd_tag, shift_idle,
           shf_sram_en, shf_sram_addr, host_we, host_addr, host_wdata,
    output cmd_ready, shift_start, shift_ctrl, start_addr, img_size, host_ready,
           sram_en, sram_we, sram_addr, sram_wdata, done_valid, done_tag, done_err, busy
  );
endinterface

// File: rtl/acc_shift_scheduler.sv
// Queues shift jobs and launches them one at a time on the shifter, holding its config for the
// whole job; also arbitrates the shared activation-SRAM port (shifter reads beat host writes).
module acc_shift_scheduler #(
  parameter int SRAM_DEPTH = 1024,
  parameter int CH         = 32,
  parameter int QDEPTH     = 4,
  parameter int TAG_W      = 4,
  parameter int START_TO   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  acc_shift_scheduler_if.slave bus
);
  localparam int ADDR_W = $clog2(SRAM_DEPTH);
  localparam int QA_W   = $clog2(QDEPTH);
  localparam int TO_W   = $clog2(START_TO + 1);
  localparam logic [QA_W:0]   QFULL   = (QA_W+1)'(QDEPTH);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(START_TO - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAITB, S_RUN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_to_err;

  logic [ADDR_W-1:0]    r_q_base [QDEPTH];
  logic [ADDR_W-1:0]    r_q_size [QDEPTH];
  logic [CH-1:0]        r_q_ctrl [QDEPTH];
  logic [TAG_W-1:0]     r_q_tag  [QDEPTH];
  logic [QA_W-1:0]      r_wptr;
  logic [QA_W-1:0]      r_rptr;
  logic [QA_W:0]        r_count;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;

  logic                 r_shift_start;
  logic [CH-1:0]        r_shift_ctrl;
  logic [ADDR_W*CH-1:0] r_start_addr;
  logic [ADDR_W-1:0]    r_img_size;
  logic [TAG_W-1:0]     r_tag;
  logic [TO_W-1:0]      r_to_cnt;
  logic                 r_done_valid;
  logic [TAG_W-1:0]     r_done_tag;
  logic                 r_done_err;

  logic                 w_sram_en;
  logic                 w_sram_we;
  logic [ADDR_W-1:0]    w_sram_addr;
  logic                 w_host_ready;

  assign w_full  = (r_count == QFULL);
  assign w_empty = (r_count == '0);
  assign w_push  = bus.cmd_valid && !w_full;
  assign w_pop   = (r_state == S_LOAD);

  // Queue payload carries no reset; only pointers and count define occupancy.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_base[r_wptr] <= bus.cmd_base;
      r_q_size[r_wptr] <= bus.cmd_size;
      r_q_ctrl[r_wptr] <= bus.cmd_ctrl;
      r_q_tag[r_wptr]  <= bus.cmd_tag;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_to_err = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_LOAD;
      S_LOAD:  w_next = S_START;
      S_START: w_next = S_WAITB;
      S_WAITB: begin
        if (!bus.shift_idle) begin
          w_next = S_RUN;
        end else if (r_to_cnt == TO_LAST) begin
          w_next   = S_DONE;
          w_to_err = 1'b1;
        end
      end
      S_RUN:   if (bus.shift_idle) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_shift_start <= 1'b0;
      r_shift_ctrl  <= '0;
      r_start_addr  <= '0;
      r_img_size    <= '0;
      r_tag         <= '0;
      r_to_cnt      <= '0;
      r_done_valid  <= 1'b0;
      r_done_tag    <= '0;
      r_done_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      // shift_start is registered off LOAD so it coincides with the START state.
      r_shift_start <= (r_state == S_LOAD);
      if (r_state == S_LOAD) begin
        r_shift_ctrl <= r_q_ctrl[r_rptr];
        r_start_addr <= {CH{r_q_base[r_rptr]}};
        r_img_size   <= r_q_size[r_rptr];
        r_tag        <= r_q_tag[r_rptr];
      end
      if (r_state == S_START)      r_to_cnt <= '0;
      else if (r_state == S_WAITB) r_to_cnt <= r_to_cnt + 1'b1;
      r_done_valid <= (w_next == S_DONE);
      if (w_next == S_DONE) begin
        r_done_tag <= r_tag;
        r_done_err <= w_to_err;
      end
    end
  end

  // Shifter reads always win the single SRAM port; host writes only take free cycles.
  always_comb begin
    w_sram_en    = 1'b0;
    w_sram_we    = 1'b0;
    w_sram_addr  = bus.host_addr;
    w_host_ready = 1'b0;
    if (bus.shf_sram_en) begin
      w_sram_en   = 1'b1;
      w_sram_addr = bus.shf_sram_addr;
    end else if (bus.host_we) begin
      w_sram_en    = 1'b1;
      w_sram_we    = 1'b1;
      w_host_ready = 1'b1;
    end
  end

  assign bus.cmd_ready   = !w_full;
  assign bus.shift_start = r_shift_start;
  assign bus.shift_ctrl  = r_shift_ctrl;
  assign bus.start_addr  = r_start_addr;
  assign bus.img_size    = r_img_size;
  assign bus.host_ready  = w_host_ready;
  assign bus.sram_en     = w_sram_en;
  assign bus.sram_we     = w_sram_we;
  assign bus.sram_addr   = w_sram_addr;
  assign bus.sram_wdata  = bus.host_wdata;
  assign bus.done_valid  = r_done_valid;
  assign bus.done_tag    = r_done_tag;
  assign bus.done_err    = r_done_err;
  assign bus.busy        = (r_state != S_IDLE) || !w_empty;
endmodule

// File: tb/tb_acc_shift_scheduler.sv
// Self-checking bench for acc_shift_scheduler: job-level reference model, behavioural shifter,
// host writer and SRAM model, all advanced once per cycle on the falling clock edge.
module tb_acc_shift_scheduler;
  localparam int AW  = 10;
  localparam int CH  = 32;
  localparam int TW  = 4;
  localparam int STO = 8;
  localparam int CW  = AW * CH;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] size;
    logic [CH-1:0] ctrl;
    logic [TW-1:0] tag;
    bit            hang;
    int            run;
    int            lat;
    int            push_cyc;
  } job_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  acc_shift_scheduler_if #(.ADDR_W(AW), .CH(CH), .TAG_W(TW)) bus ();

  acc_shift_scheduler #(
    .SRAM_DEPTH(1024), .CH(CH), .QDEPTH(4), .TAG_W(TW), .START_TO(STO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  job_t          exp_q[$];
  job_t          cur;
  job_t          nxt;
  logic [TW-1:0] done_tags[$];
  logic [CH-1:0] mem [1024];
  logic [CH-1:0] exp_mem [int];
  int  n_chk = 0, n_fail = 0;
  int  cyc = 0, phase = 0, dly = 0, run_left = 0, start_cyc = 0, idle_cyc = 0;
  int  n_done = 0, n_launch = 0;
  bit  accepted = 0, host_on = 0;
  logic ready_pre = 1'b0;
  logic [AW-1:0] rd_addr;

  always @(posedge clk) if (bus.sram_en && bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;

  task automatic chk(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One cycle: observe at the falling edge, update the models, then drive the next inputs.
  task automatic tick();
    logic          e_en, e_we;
    logic [AW-1:0] e_addr;
    @(negedge clk);
    cyc++;
    accepted = 0;
    if (bus.cmd_valid && ready_pre) begin
      nxt.push_cyc = cyc - 1;
      exp_q.push_back(nxt);
      accepted = 1;
    end
    e_en   = bus.shf_sram_en || bus.host_we;
    e_we   = !bus.shf_sram_en && bus.host_we;
    e_addr = bus.shf_sram_en ? bus.shf_sram_addr : bus.host_addr;
    chk("sram_en", bus.sram_en, e_en);
    chk("sram_we", bus.sram_we, e_we);
    chk("host_ready", bus.host_ready, e_we);
    chk("sram_wdata", bus.sram_wdata, bus.host_wdata);
    if (e_en) chk("sram_addr", bus.sram_addr, e_addr);
    if (e_we) exp_mem[int'(bus.host_addr)] = bus.host_wdata;

    if (bus.done_valid) begin
      chk("done_pending", phase == 3, 1'b1);
      if (phase == 3) begin
        chk("done_tag", bus.done_tag, cur.tag);
        chk("done_err", bus.done_err, cur.hang);
        chk("done_lat", cyc, cur.hang ? start_cyc + STO + 1 : idle_cyc + 1);
        chk("cfg_hold_size", bus.img_size, cur.size);
        chk("cfg_hold_addr", bus.start_addr, {CH{cur.base}});
        done_tags.push_back(bus.done_tag);
        n_done++;
        phase = 0;
      end
    end else if (phase != 0 && cyc - start_cyc > 300) begin
      chk("job_timeout", phase, 0);
      phase = 0;
    end

    if (bus.shift_start) begin
      chk("start_when_free", phase, 0);
      chk("start_has_job", exp_q.size() > 0, 1'b1);
      if (phase == 0 && exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        n_launch++;
        start_cyc = cyc;
        chk("cfg_ctrl", bus.shift_ctrl, cur.ctrl);
        chk("cfg_size", bus.img_size, cur.size);
        chk("cfg_addr", bus.start_addr, {CH{cur.base}});
        if (cur.lat > 0) chk("start_lat", cyc - cur.push_cyc, cur.lat);
        if (cur.hang) phase = 3;
        else begin
          phase = 1;
          dly   = $urandom_range(0, 3);
        end
      end
    end

    case (phase)
      1: if (dly == 0) begin
           bus.shift_idle = 1'b0;
           run_left = cur.run;
           rd_addr  = cur.base;
           phase    = 2;
         end else dly--;
      2: if (run_left > 0) begin
           bus.shf_sram_en   = 1'b1;
           bus.shf_sram_addr = rd_addr;
           rd_addr++;
           run_left--;
         end else begin
           bus.shf_sram_en = 1'b0;
           bus.shift_idle  = 1'b1;
           idle_cyc = cyc;
           phase    = 3;
         end
      default: ;
    endcase

    if (!host_on) bus.host_we = 1'b0;
    else if (!bus.host_we || e_we) begin
      bus.host_we    = 1'b1;
      bus.host_addr  = AW'($urandom_range(0, 1023));
      bus.host_wdata = $urandom;
    end
    ready_pre = bus.cmd_ready;
  endtask

  task automatic push(input logic [AW-1:0] base, input logic [AW-1:0] size, input logic [CH-1:0] ctrl,
                      input logic [TW-1:0] tag, input bit hang, input int run, input int lat);
    int n = 0;
    nxt = '{base: base, size: size, ctrl: ctrl, tag: tag, hang: hang, run: run, lat: lat, push_cyc: 0};
    bus.cmd_base = base;
    bus.cmd_size = size;
    bus.cmd_ctrl = ctrl;
    bus.cmd_tag  = tag;
    bus.cmd_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!accepted && n < 300);
    chk("push_accept", accepted, 1'b1);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic push_rand(input logic [TW-1:0] tag, input int run);
    push(AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)), $urandom, tag, 1'b0, run, 0);
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (phase != p && n < 200) begin
      tick();
      n++;
    end
    chk("wait_phase", phase, p);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || phase != 0) && n < 3000) begin
      tick();
      n++;
    end
    chk("drain_done", exp_q.size() == 0 && phase == 0, 1'b1);
    tick();
    chk("drain_busy", bus.busy, 1'b0);
  endtask

  initial begin
    int l0, d0, n;
    logic [TW-1:0] want;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_base = '0; bus.cmd_size = '0; bus.cmd_ctrl = '0; bus.cmd_tag = '0;
    bus.shift_idle = 1'b1; bus.shf_sram_en = 1'b0; bus.shf_sram_addr = '0;
    bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_shift_start", bus.shift_start, 1'b0);
    chk("rst_shift_ctrl", bus.shift_ctrl, '0);
    chk("rst_start_addr", bus.start_addr, '0);
    chk("rst_img_size", bus.img_size, '0);
    chk("rst_done_valid", bus.done_valid, 1'b0);
    chk("rst_done_tag", bus.done_tag, '0);
    chk("rst_done_err", bus.done_err, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);

    // Single job into an idle DUT: launch latency, config and completion.
    push(10'd0, 10'd31, 32'hA5A5_0F0F, 4'd3, 1'b0, 4, 3);
    drain();
    chk("t1_done_count", n_done, 1);
    chk("t1_tag", done_tags[0], 4'd3);

    // Fill the queue behind a long-running job; completion order and one launch per job.
    done_tags.delete();
    l0 = n_launch;
    push_rand(4'hF, 40);
    wait_phase(2);
    for (int i = 0; i < 4; i++) push_rand(TW'(i), $urandom_range(1, 4));
    chk("t2_full_ready", bus.cmd_ready, 1'b0);
    push_rand(4'd4, 2);
    drain();
    chk("t2_launches", n_launch - l0, 6);
    chk("t2_done_count", done_tags.size(), 6);
    for (int i = 0; i < done_tags.size(); i++) begin
      want = (i == 0) ? 4'hF : TW'(i - 1);
      chk("t2_order", done_tags[i], want);
    end

    // Shifter never goes busy: timeout completion, then the next job still runs.
    d0 = n_done;
    push(AW'($urandom_range(0, 1023)), 10'd7, $urandom, 4'd7, 1'b1, 0, 0);
    push_rand(4'd8, 3);
    drain();
    chk("t3_done_count", n_done - d0, 2);

    // Host writes contend with a 32-word shifter read burst.
    host_on = 1;
    push(AW'($urandom_range(0, 1023)), 10'd31, $urandom, 4'd9, 1'b0, 32, 0);
    drain();
    host_on = 0;
    repeat (2) tick();
    chk("t4_writes_seen", exp_mem.size() > 0, 1'b1);

    // Randomized job mix with random gaps and host traffic.
    d0 = n_done;
    for (int i = 0; i < 12; i++) begin
      host_on = ($urandom_range(0, 1) == 1);
      push(AW'($urandom_range(0, 1023)), AW'($urandom_range(0, 1023)), $urandom, TW'($urandom),
           ($urandom_range(0, 4) == 0), $urandom_range(1, 6), 0);
      repeat ($urandom_range(0, 6)) tick();
    end
    drain();
    host_on = 0;
    chk("rand_done_count", n_done - d0, 12);

    // Reset while the shifter runs, with another job queued: everything is abandoned.
    push_rand(4'd10, 30);
    wait_phase(2);
    push_rand(4'd11, 2);
    l0 = n_launch;
    d0 = n_done;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    phase = 0;
    bus.shift_idle  = 1'b1;
    bus.shf_sram_en = 1'b0;
    chk("t5_shift_start", bus.shift_start, 1'b0);
    chk("t5_done_valid", bus.done_valid, 1'b0);
    chk("t5_busy", bus.busy, 1'b0);
    chk("t5_cmd_ready", bus.cmd_ready, 1'b1);
    repeat (15) tick();
    chk("t5_no_launch", n_launch, l0);
    chk("t5_no_done", n_done, d0);

    // Push during the DONE cycle of the previous job.
    d0 = n_done;
    push(10'd100, 10'd5, 32'h1234_5678, 4'd12, 1'b0, 3, 3);
    n = 0;
    while (n_done == d0 && n < 200) begin
      tick();
      n++;
    end
    chk("t6_first_done", n_done - d0, 1);
    push(10'd200, 10'd9, 32'hCAFE_F00D, 4'd13, 1'b0, 2, 3);
    drain();
    chk("t6_done_count", n_done - d0, 2);
    chk("t6_last_tag", done_tags[done_tags.size() - 1], 4'd13);

    foreach (exp_mem[a]) chk("readback", mem[a], exp_mem[a]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
